// File: rtl/led_disp_arbiter_if.sv
// Requester handshake and LED pin bundle for led_disp_arbiter.
// master = requester/board side, slave = arbiter side.
interface led_disp_arbiter_if #(
  parameter int DW = 16
);
  logic          req0;
  logic [DW-1:0] data0;
  logic          gnt0;
  logic          req1;
  logic [DW-1:0] data1;
  logic          gnt1;
  logic          busy;
  logic          led_clk;
  logic          led_do;
  logic          led_clr;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, busy, led_clk, led_do, led_clr
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, busy, led_clk, led_do, led_clr
  );
endinterface

// File: rtl/led_disp_arbiter.sv
// Round-robin sharing of a serial LED shift-register display between two requesters.
// Optional LED_ACTIVE_LOW_EN: invert the latched word before it is shifted out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request; arbitrates on every cycle
// S_GRANT | one-cycle grant pulse, word latched on entry
// S_CLEAR | led_clr held low for 2*CLK_DIV cycles
// S_SHIFT | DW bits MSB first, each bit CLK_DIV low then CLK_DIV high
// S_DONE  | one-cycle wrap-up, last-grant pointer updated
module led_disp_arbiter #(
  parameter int DW      = 16,
  parameter int CLK_DIV = 100
) (
  input logic              clk,
  input logic              RSTN,
  led_disp_arbiter_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] HALF_TC  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_CLEAR,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] word;
  logic          last_gnt;
  logic          cur_gnt;
  logic          gnt0_q;
  logic          gnt1_q;
  logic          busy_q;
  logic          led_clk_q;
  logic          led_do_q;
  logic          led_clr_q;

  logic          pick1;
  logic [DW-1:0] word_load;
  logic [DW-1:0] word_shl;

  // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
  always_comb begin
    pick1 = bus.req1 && (!bus.req0 || !last_gnt);
  end

  always_comb begin
    word_load = pick1 ? bus.data1 : bus.data0;
`ifdef LED_ACTIVE_LOW_EN
    word_load = ~word_load;
`else
    word_load = word_load;
`endif
    word_shl = word << 1;
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      word      <= '0;
      last_gnt  <= 1'b1;
      cur_gnt   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      led_clk_q <= 1'b0;
      led_do_q  <= 1'b0;
      led_clr_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (bus.req0 || bus.req1) begin
            state   <= S_GRANT;
            gnt0_q  <= !pick1;
            gnt1_q  <= pick1;
            cur_gnt <= pick1;
            word    <= word_load;
            busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          gnt0_q    <= 1'b0;
          gnt1_q    <= 1'b0;
          led_clr_q <= 1'b0;
          led_clk_q <= 1'b0;
          led_do_q  <= 1'b0;
          div_cnt   <= '0;
          state     <= S_CLEAR;
        end
        S_CLEAR: begin
          if (div_cnt == FULL_TC) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            led_clr_q <= 1'b1;
            led_do_q  <= word[DW-1];
            state     <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        S_SHIFT: begin
          if (div_cnt == FULL_TC) begin
            div_cnt   <= '0;
            led_clk_q <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              led_do_q <= 1'b0;
              state    <= S_DONE;
            end else begin
              bit_cnt  <= bit_cnt + BW'(1);
              word     <= word_shl;
              led_do_q <= word_shl[DW-1];
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
            if (div_cnt == HALF_TC) begin
              led_clk_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          last_gnt  <= cur_gnt;
          busy_q    <= 1'b0;
          led_do_q  <= 1'b0;
          led_clk_q <= 1'b0;
          div_cnt   <= '0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = busy_q;
  assign bus.led_clk = led_clk_q;
  assign bus.led_do  = led_do_q;
  assign bus.led_clr = led_clr_q;

endmodule

// File: tb/tb_led_disp_arbiter.sv
// Bench for led_disp_arbiter (DW=16, CLK_DIV=2): fixed vector table, multi-cycle
// corner sequences and randomized frames against a round-robin reference model.
module tb_led_disp_arbiter;
  localparam int DW      = 16;
  localparam int CLK_DIV = 2;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  int   gnt0_cnt = 0;

  led_disp_arbiter_if #(.DW(DW)) bus ();

  led_disp_arbiter #(.DW(DW), .CLK_DIV(CLK_DIV)) dut (
    .clk  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.gnt0 === 1'b1) gnt0_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          r0;
    bit          r1;
    logic [15:0] d0;
    logic [15:0] d1;
    int          eg;
    logic [15:0] ew;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] disp(input logic [15:0] w);
`ifdef LED_ACTIVE_LOW_EN
    return ~w;
`else
    return w;
`endif
  endfunction

  // Runs one frame from request to busy falling; checks frame shape, returns grant/bits.
  task automatic do_frame(input bit r0, input bit r1, input logic [15:0] d0,
                          input logic [15:0] d1, input bit drop,
                          output int g, output logic [15:0] bits, output int gap);
    int busy_cyc, gnt_cyc, clr_cyc, edges;
    bit prev_clk, got;
    bus.req0 = r0; bus.req1 = r1; bus.data0 = d0; bus.data1 = d1;
    g = -1; bits = '0; gap = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      gap++;
      if (bus.gnt0 || bus.gnt1) got = 1;
    end
    if (!got) begin
      check("grant_timeout", 0, 1);
      return;
    end
    g = bus.gnt1 ? 1 : 0;
    check("gnt_both", int'(bus.gnt0 && bus.gnt1), 0);
    check("busy_at_grant", int'(bus.busy), 1);
    if (drop) begin
      bus.req0 = 1'b0; bus.req1 = 1'b0;
    end
    bus.data0 = ~d0; bus.data1 = ~d1;
    busy_cyc = 1; gnt_cyc = 1; clr_cyc = 0; edges = 0; prev_clk = bus.led_clk;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      busy_cyc++;
      if (bus.gnt0 || bus.gnt1) gnt_cyc++;
      if (!bus.led_clr) clr_cyc++;
      if (bus.led_clk && !prev_clk) begin
        bits = {bits[14:0], bus.led_do};
        edges++;
      end
      prev_clk = bus.led_clk;
    end
    check("busy_len", busy_cyc, 70);
    check("clr_len", clr_cyc, 4);
    check("clk_edges", edges, 16);
    check("gnt_len", gnt_cyc, 1);
    check("led_clk_idle", int'(bus.led_clk), 0);
    check("led_do_idle", int'(bus.led_do), 0);
  endtask

  initial begin
    vec_t        vecs[7];
    int          g, gap, base, e4, last, exp_g, sel;
    bit          prev4, hit, got;
    logic [15:0] bits, d0, d1;

    vecs[0] = '{1'b1, 1'b0, 16'h0013, 16'h0000, 0, 16'h0013};
    vecs[1] = '{1'b1, 1'b1, 16'hA5A5, 16'h5A5A, 1, 16'h5A5A};
    vecs[2] = '{1'b1, 1'b1, 16'h8001, 16'hFFFF, 0, 16'h8001};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h1234, 1, 16'h1234};
    vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 0, 16'hFFFF};
    vecs[6] = '{1'b1, 1'b0, 16'h00FF, 16'hC3C3, 0, 16'h00FF};

    rstn = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt0", int'(bus.gnt0), 0);
    check("rst_gnt1", int'(bus.gnt1), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_led_clk", int'(bus.led_clk), 0);
    check("rst_led_do", int'(bus.led_do), 0);
    check("rst_led_clr", int'(bus.led_clr), 1);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_frame(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1, 1'b1, g, bits, gap);
      check($sformatf("vec%0d_gnt", i), g, vecs[i].eg);
      check($sformatf("vec%0d_bits", i), int'(bits), int'(disp(vecs[i].ew)));
    end

    // One-cycle req0 pulse during a req1 frame is lost.
    bus.req1 = 1'b1; bus.data1 = 16'h0F0F; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt1) got = 1;
    end
    check("t5_gnt1", int'(got), 1);
    bus.req1 = 1'b0;
    base = gnt0_cnt;
    repeat (10) @(negedge clk);
    check("t5_busy_mid", int'(bus.busy), 1);
    bus.req0 = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b0;
    repeat (150) @(negedge clk);
    check("t5_no_gnt0", gnt0_cnt - base, 0);
    check("t5_idle", int'(bus.busy), 0);

    // Reset during shift bit 7, then both requests held: gnt0,gnt1,gnt0,gnt1.
    bus.req0 = 1'b1; bus.data0 = 16'hFFFF; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt0) got = 1;
    end
    check("t4_gnt0", int'(got), 1);
    bus.req0 = 1'b0;
    e4 = 0; prev4 = bus.led_clk; hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (bus.led_clk && !prev4) e4++;
      prev4 = bus.led_clk;
      if (e4 == 7 && !bus.led_clk) hit = 1;
    end
    check("t4_reach_bit7", int'(hit), 1);
    check("t4_busy_before", int'(bus.busy), 1);
    rstn = 1'b0;
    #1;
    check("t4_busy", int'(bus.busy), 0);
    check("t4_led_clr", int'(bus.led_clr), 1);
    check("t4_led_clk", int'(bus.led_clk), 0);
    check("t4_led_do", int'(bus.led_do), 0);
    check("t4_gnt", int'(bus.gnt0 || bus.gnt1), 0);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_frame(1'b1, 1'b1, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0, g, bits, gap);
      check($sformatf("t2_gnt%0d", i), g, i % 2);
      check($sformatf("t2_gap%0d", i), gap, 1);
      check($sformatf("t2_bits%0d", i), int'(bits),
            int'(disp((i % 2) ? 16'h2000 + 16'(i) : 16'h1000 + 16'(i))));
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // req1 alone, held: granted every frame, gnt0 never.
    base = gnt0_cnt;
    for (int i = 0; i < 2; i++) begin
      do_frame(1'b0, 1'b1, 16'hAAAA, 16'h0F00 + 16'(i), 1'b0, g, bits, gap);
      check($sformatf("t3_gnt%0d", i), g, 1);
    end
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_no_gnt0", gnt0_cnt - base, 0);

    // Randomized frames against the round-robin model.
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    last = 1;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(1, 3);
      d0  = 16'($urandom);
      d1  = 16'($urandom);
      if (sel == 3) exp_g = (last == 1) ? 0 : 1;
      else          exp_g = (sel == 2) ? 1 : 0;
      do_frame(sel[0], sel[1], d0, d1, 1'b1, g, bits, gap);
      check($sformatf("rnd%0d_gnt", i), g, exp_g);
      check($sformatf("rnd%0d_bits", i), int'(bits), int'(disp(exp_g ? d1 : d0)));
      last = exp_g;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
